toy_bpu_pcgen: RTL and testbench
================================

TOY_BPU_PCGEN -- requirements
Module: toy_bpu_pcgen

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, PC width.
REQ-002 SHALL have parameter RESET_PC, default 32'h8000_0000, first fetch PC after reset.
REQ-003 SHALL have parameter CREDIT_NUM, default 8, fetch-queue slots downstream; legal range 1..255.
REQ-004 SHALL have port clk, input, 1, clock.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port be_redirect_vld, input, 1, backend flush/redirect.
REQ-007 SHALL have port be_redirect_pc, input, ADDR_WIDTH, backend redirect target.
REQ-008 SHALL have port bpdec_redirect_vld, input, 1, later-stage predictor override.
REQ-009 SHALL have port bpdec_redirect_pc, input, ADDR_WIDTH, override target.
REQ-010 SHALL have port be_hold, input, 1, backend request to stop fetch issue.
REQ-011 SHALL have port l0btb_nxt_vld, input, 1, same-cycle next-PC valid from L0 BTB.
REQ-012 SHALL have port l0btb_nxt_pc, input, ADDR_WIDTH, L0 BTB aligned next PC.
REQ-013 SHALL have port credit_return, input, 1, one fetch-queue slot freed.
REQ-014 SHALL have port pcgen_vld, output, 1, PC issued this cycle.
REQ-015 SHALL have port pcgen_pc, output, ADDR_WIDTH, issued PC.

Function
REQ-016 SHALL hold pc_q, credit_cnt ($clog2(CREDIT_NUM+1) bits), state in {BOOT, RUN, STALL, HOLD}.
REQ-017 SHALL drive pcgen_pc = pc_q combinationally, every cycle.
REQ-018 SHALL assert pcgen_vld = (state==RUN) && credit_cnt!=0 && !be_redirect_vld && !bpdec_redirect_vld && !be_hold.
REQ-019 SHALL select next pc_q by priority: be_redirect_pc > bpdec_redirect_pc > l0btb_nxt_pc (when pcgen_vld && l0btb_nxt_vld) > pc_q.
REQ-020 SHALL apply a redirect in any state, including BOOT, STALL and HOLD; the redirected PC is issued no earlier than the next cycle.
REQ-021 SHALL ignore l0btb_nxt_vld when pcgen_vld is low.
REQ-022 SHALL compute credit_cnt_next = credit_cnt - pcgen_vld + credit_return; a simultaneous issue and return leaves the count unchanged.
REQ-023 SHALL ignore credit_return when credit_cnt==CREDIT_NUM and !pcgen_vld (no wrap); a simulation assertion SHALL flag it.
REQ-024 SHALL leave credits unaffected by redirects; the backend returns flushed slots via credit_return.
REQ-025 SHALL transition BOOT->RUN unconditionally after one cycle, with no issue in BOOT.
REQ-026 SHALL transition RUN->HOLD when be_hold; else RUN->STALL when credit_cnt_next==0.
REQ-027 SHALL transition STALL->HOLD when be_hold; else STALL->RUN when credit_cnt_next!=0.
REQ-028 SHALL transition HOLD->RUN when !be_hold && credit_cnt_next!=0; HOLD->STALL when !be_hold && credit_cnt_next==0.
REQ-029 SHALL have zero-cycle issue latency from pc_q: one PC per cycle in RUN with credits available.

Reset
REQ-030 SHALL set pc_q=RESET_PC, credit_cnt=CREDIT_NUM, state=BOOT on rst_n low, asynchronously.
REQ-031 SHALL hold pcgen_vld=0 and pcgen_pc=RESET_PC during reset.
REQ-032 SHALL discard any in-flight redirect or credit state when reset is asserted mid-operation.

Structure
REQ-033 SHALL place the state enum (pcgen_state_e), RESET_PC and CREDIT_NUM defaults in toy_pack.
REQ-034 SHALL contain one sub-module, toy_bpu_pcgen_credit (saturating up/down credit counter with zero/full flags).

Verification
REQ-035 SHALL cover reset release: cycle 0 BOOT with vld=0; cycle 1 vld=1 with pc=8000_0000.
REQ-036 SHALL cover an L0 BTB chain: nxt_pc 8000_0010 then 8000_0040 -> issued 8000_0000, 8000_0010, 8000_0040 on consecutive cycles.
REQ-037 SHALL cover redirect priority: be=1000_0000, bpdec=2000_0000 and l0btb valid in the same cycle -> vld=0 that cycle; next cycle pc=1000_0000.
REQ-038 SHALL cover credit exhaustion: CREDIT_NUM=2 with no returns -> two issues, then STALL with vld=0; one credit_return -> one further issue the following cycle.
REQ-039 SHALL cover hold: be_hold for 3 cycles with be_redirect 4000_0000 during the hold -> vld=0 for 3 cycles, then pc=4000_0000 issued.
REQ-040 SHALL cover simultaneous issue and return at credit_cnt=1 -> count stays 1 and state stays RUN.

Source files
------------

// File: rtl/toy_pack.sv
// Shared types and defaults for the branch-predictor PC generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package toy_pack;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    HOLD  = 2'd3
  } pcgen_state_e;

  localparam logic [31:0] PCGEN_RESET_PC   = 32'h8000_0000;
  localparam int          PCGEN_CREDIT_NUM = 8;

  // Counter width able to hold every value 0..n inclusive.
  function automatic int credit_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/toy_bpu_pcgen_credit.sv
// Saturating up/down fetch-queue credit counter with zero/full flags.
// Latency: count updates one cycle after dec/inc; nxt_zero is combinational.
// Backpressure: dec at zero and inc at full are dropped (no wrap).
module toy_bpu_pcgen_credit
  import toy_pack::*;
#(
  parameter int CREDIT_NUM = PCGEN_CREDIT_NUM,
  parameter int CW         = credit_width(CREDIT_NUM)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dec,
  input  logic inc,
  output logic zero,
  output logic full,
  output logic nxt_zero
);

  localparam logic [CW-1:0] CNT_MAX = CW'(CREDIT_NUM);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign zero     = (cnt_q == '0);
  assign full     = (cnt_q == CNT_MAX);
  assign nxt_zero = (cnt_d == '0);

  // Next count: issue consumes, return frees; both together cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (dec && !inc && !zero) begin
      cnt_d = cnt_q - CW'(1);
    end else if (inc && !dec && !full) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register; reset refills the whole downstream queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CNT_MAX;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/toy_bpu_pcgen.sv
// Fetch PC generator: picks next PC from redirects / L0 BTB, issues under credits.
// Latency: zero-cycle issue from pc_q; redirects take effect the following cycle.
// Backpressure: credit-based; no issue when credits are 0, be_hold or any redirect.
module toy_bpu_pcgen
  import toy_pack::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(PCGEN_RESET_PC),
  parameter int                    CREDIT_NUM = PCGEN_CREDIT_NUM
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  be_redirect_vld,
  input  logic [ADDR_WIDTH-1:0] be_redirect_pc,
  input  logic                  bpdec_redirect_vld,
  input  logic [ADDR_WIDTH-1:0] bpdec_redirect_pc,
  input  logic                  be_hold,
  input  logic                  l0btb_nxt_vld,
  input  logic [ADDR_WIDTH-1:0] l0btb_nxt_pc,
  input  logic                  credit_return,
  output logic                  pcgen_vld,
  output logic [ADDR_WIDTH-1:0] pcgen_pc
);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_d;
  pcgen_state_e          state_q;
  pcgen_state_e          state_d;
  logic                  credit_zero;
  logic                  credit_full;
  logic                  credit_nxt_zero;

  toy_bpu_pcgen_credit #(
    .CREDIT_NUM (CREDIT_NUM)
  ) u_credit (
    .clk      (clk),
    .rst_n    (rst_n),
    .dec      (pcgen_vld),
    .inc      (credit_return),
    .zero     (credit_zero),
    .full     (credit_full),
    .nxt_zero (credit_nxt_zero)
  );

  assign pcgen_pc = pc_q;

  // Next PC priority: backend redirect, then decode override, then L0 BTB on issue.
  always_comb begin
    pc_d = pc_q;
    if (be_redirect_vld) begin
      pc_d = be_redirect_pc;
    end else if (bpdec_redirect_vld) begin
      pc_d = bpdec_redirect_pc;
    end else if (pcgen_vld && l0btb_nxt_vld) begin
      pc_d = l0btb_nxt_pc;
    end
  end

  // PC and state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      state_q <= BOOT;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  // Next state: hold dominates; otherwise track whether credits remain next cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:  state_d = RUN;
      RUN: begin
        if (be_hold)              state_d = HOLD;
        else if (credit_nxt_zero) state_d = STALL;
      end
      STALL: begin
        if (be_hold)               state_d = HOLD;
        else if (!credit_nxt_zero) state_d = RUN;
      end
      HOLD: begin
        if (!be_hold) state_d = credit_nxt_zero ? STALL : RUN;
      end
      default: state_d = BOOT;
    endcase
  end

  // Issue only in RUN with a credit and nothing steering the PC away this cycle.
  always_comb begin
    pcgen_vld = (state_q == RUN) && !credit_zero && !be_redirect_vld &&
                !bpdec_redirect_vld && !be_hold;
  end

`ifndef SYNTHESIS
  // A return into a full pool means the backend's slot accounting is broken.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(credit_return && credit_full && !pcgen_vld))
        else $error("credit_return with credit pool already full");
    end
  end
`endif

endmodule

// File: tb/tb_toy_bpu_pcgen.sv
// Self-checking bench for toy_bpu_pcgen with a two-slot credit pool.
// Latency: expected issues are queued when driven and popped on each pcgen_vld.
// Backpressure: bench drives credit_return directly to exercise stall/refill.
module tb_toy_bpu_pcgen;
  import toy_pack::*;

  localparam int          AW  = 32;
  localparam logic [31:0] RPC = 32'h8000_0000;
  localparam int          CN  = 2;

  logic          clk;
  logic          rst_n;
  logic          be_redirect_vld;
  logic [AW-1:0] be_redirect_pc;
  logic          bpdec_redirect_vld;
  logic [AW-1:0] bpdec_redirect_pc;
  logic          be_hold;
  logic          l0btb_nxt_vld;
  logic [AW-1:0] l0btb_nxt_pc;
  logic          credit_return;
  logic          pcgen_vld;
  logic [AW-1:0] pcgen_pc;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] exp_pc;

  toy_bpu_pcgen #(
    .ADDR_WIDTH (AW),
    .RESET_PC   (RPC),
    .CREDIT_NUM (CN)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .be_redirect_vld    (be_redirect_vld),
    .be_redirect_pc     (be_redirect_pc),
    .bpdec_redirect_vld (bpdec_redirect_vld),
    .bpdec_redirect_pc  (bpdec_redirect_pc),
    .be_hold            (be_hold),
    .l0btb_nxt_vld      (l0btb_nxt_vld),
    .l0btb_nxt_pc       (l0btb_nxt_pc),
    .credit_return      (credit_return),
    .pcgen_vld          (pcgen_vld),
    .pcgen_pc           (pcgen_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every issued PC must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && pcgen_vld === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL issue_unexpected: got pc %h, want no issue", pcgen_pc);
      end else begin
        exp_pc = exp_q.pop_front();
        if (pcgen_pc !== exp_pc) begin
          n_err++;
          $display("FAIL issue_pc: got %h want %h", pcgen_pc, exp_pc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    be_redirect_vld    = 1'b0;
    be_redirect_pc     = '0;
    bpdec_redirect_vld = 1'b0;
    bpdec_redirect_pc  = '0;
    be_hold            = 1'b0;
    l0btb_nxt_vld      = 1'b0;
    l0btb_nxt_pc       = '0;
    credit_return      = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Leaves the bench just after the edge that starts BOOT (cycle 0).
  task automatic apply_reset();
    next_cycle();
    rst_n = 1'b0;
    drive_idle();
    next_cycle();
    next_cycle();
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    next_cycle();
    rst_n = 1'b0;
    drive_idle();
    settle();
    n_cmp++; if (pcgen_vld !== 1'b0) begin n_err++; $display("FAIL rst_vld: got %b want 0", pcgen_vld); end
    n_cmp++; if (pcgen_pc !== RPC) begin n_err++; $display("FAIL rst_pc: got %h want %h", pcgen_pc, RPC); end
    next_cycle();
    rst_n = 1'b1;
    settle();
    n_cmp++; if (pcgen_vld !== 1'b0) begin n_err++; $display("FAIL boot_vld: got %b want 0", pcgen_vld); end
    n_cmp++; if (dut.state_q !== BOOT) begin n_err++; $display("FAIL boot_state: got %0d want %0d", dut.state_q, BOOT); end
    next_cycle();
    exp_q.push_back(RPC);
    settle();
    n_cmp++; if (pcgen_vld !== 1'b1) begin n_err++; $display("FAIL first_issue_vld: got %b want 1", pcgen_vld); end
    next_cycle();
    be_hold = 1'b1;
    settle();
    n_cmp++; if (pcgen_vld !== 1'b0) begin n_err++; $display("FAIL reset_hold_vld: got %b want 0", pcgen_vld); end
    next_cycle();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL reset_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_l0btb_chain();
    apply_reset();
    next_cycle();
    l0btb_nxt_vld = 1'b1; l0btb_nxt_pc = 32'h8000_0010; credit_return = 1'b1;
    exp_q.push_back(32'h8000_0000);
    settle();
    n_cmp++; if (pcgen_vld !== 1'b1) begin n_err++; $display("FAIL chain_vld0: got %b want 1", pcgen_vld); end
    next_cycle();
    l0btb_nxt_pc = 32'h8000_0040;
    exp_q.push_back(32'h8000_0010);
    settle();
    n_cmp++; if (pcgen_vld !== 1'b1) begin n_err++; $display("FAIL chain_vld1: got %b want 1", pcgen_vld); end
    next_cycle();
    l0btb_nxt_vld = 1'b0;
    exp_q.push_back(32'h8000_0040);
    settle();
    n_cmp++; if (pcgen_vld !== 1'b1) begin n_err++; $display("FAIL chain_vld2: got %b want 1", pcgen_vld); end
    // With no issue the L0 BTB target must not be taken.
    next_cycle();
    credit_return = 1'b0; be_hold = 1'b1;
    l0btb_nxt_vld = 1'b1; l0btb_nxt_pc = 32'h8000_0FF0;
    settle();
    n_cmp++; if (pcgen_vld !== 1'b0) begin n_err++; $display("FAIL chain_hold_vld: got %b want 0", pcgen_vld); end
    next_cycle();
    settle();
    n_cmp++; if (pcgen_pc !== 32'h8000_0040) begin n_err++; $display("FAIL l0_ignored_pc: got %h want 80000040", pcgen_pc); end
    next_cycle();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL chain_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_redirect_priority();
    apply_reset();
    bpdec_redirect_vld = 1'b1; bpdec_redirect_pc = 32'h5000_0000;
    settle();
    n_cmp++; if (pcgen_vld !== 1'b0) begin n_err++; $display("FAIL boot_redir_vld: got %b want 0", pcgen_vld); end
    next_cycle();
    be_redirect_vld = 1'b1; be_redirect_pc = 32'h1000_0000;
    bpdec_redirect_pc = 32'h2000_0000;
    l0btb_nxt_vld = 1'b1; l0btb_nxt_pc = 32'h3000_0000;
    settle();
    n_cmp++; if (pcgen_pc !== 32'h5000_0000) begin n_err++; $display("FAIL boot_redir_pc: got %h want 50000000", pcgen_pc); end
    n_cmp++; if (pcgen_vld !== 1'b0) begin n_err++; $display("FAIL prio_vld: got %b want 0", pcgen_vld); end
    next_cycle();
    drive_idle();
    exp_q.push_back(32'h1000_0000);
    settle();
    n_cmp++; if (pcgen_vld !== 1'b1) begin n_err++; $display("FAIL prio_issue_vld: got %b want 1", pcgen_vld); end
    next_cycle();
    bpdec_redirect_vld = 1'b1; bpdec_redirect_pc = 32'h2000_0000;
    l0btb_nxt_vld = 1'b1; l0btb_nxt_pc = 32'h3000_0000;
    settle();
    n_cmp++; if (pcgen_vld !== 1'b0) begin n_err++; $display("FAIL bpdec_vld: got %b want 0", pcgen_vld); end
    next_cycle();
    drive_idle();
    exp_q.push_back(32'h2000_0000);
    settle();
    // Last credit used: next cycle is STALL; redirect and refill land together.
    next_cycle();
    be_redirect_vld = 1'b1; be_redirect_pc = 32'h6000_0000; credit_return = 1'b1;
    settle();
    n_cmp++; if (pcgen_vld !== 1'b0) begin n_err++; $display("FAIL stall_redir_vld: got %b want 0", pcgen_vld); end
    next_cycle();
    drive_idle();
    exp_q.push_back(32'h6000_0000);
    settle();
    next_cycle();
    settle();
    n_cmp++; if (pcgen_vld !== 1'b0) begin n_err++; $display("FAIL prio_tail_vld: got %b want 0", pcgen_vld); end
    next_cycle();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL prio_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_credit_exhaust();
    apply_reset();
    next_cycle();
    l0btb_nxt_vld = 1'b1; l0btb_nxt_pc = 32'h8000_0004;
    exp_q.push_back(RPC);
    settle();
    next_cycle();
    l0btb_nxt_pc = 32'h8000_0008;
    exp_q.push_back(32'h8000_0004);
    settle();
    next_cycle();
    l0btb_nxt_pc = 32'h8000_00F0;
    settle();
    n_cmp++; if (pcgen_vld !== 1'b0) begin n_err++; $display("FAIL exhaust_vld: got %b want 0", pcgen_vld); end
    n_cmp++; if (dut.state_q !== STALL) begin n_err++; $display("FAIL exhaust_state: got %0d want %0d", dut.state_q, STALL); end
    next_cycle();
    credit_return = 1'b1;
    settle();
    n_cmp++; if (pcgen_vld !== 1'b0) begin n_err++; $display("FAIL refill_vld: got %b want 0", pcgen_vld); end
    next_cycle();
    drive_idle();
    exp_q.push_back(32'h8000_0008);
    settle();
    n_cmp++; if (pcgen_vld !== 1'b1) begin n_err++; $display("FAIL refill_issue: got %b want 1", pcgen_vld); end
    next_cycle();
    settle();
    n_cmp++; if (pcgen_vld !== 1'b0) begin n_err++; $display("FAIL reexhaust_vld: got %b want 0", pcgen_vld); end
    next_cycle();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL exhaust_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_hold();
    apply_reset();
    next_cycle();
    be_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      be_redirect_vld = (i == 1);
      be_redirect_pc  = 32'h4000_0000;
      settle();
      n_cmp++; if (pcgen_vld !== 1'b0) begin n_err++; $display("FAIL hold_vld[%0d]: got %b want 0", i, pcgen_vld); end
      next_cycle();
    end
    // HOLD exit is registered, so one bubble follows the release.
    drive_idle();
    settle();
    n_cmp++; if (pcgen_vld !== 1'b0) begin n_err++; $display("FAIL hold_exit_vld: got %b want 0", pcgen_vld); end
    n_cmp++; if (dut.state_q !== HOLD) begin n_err++; $display("FAIL hold_state: got %0d want %0d", dut.state_q, HOLD); end
    next_cycle();
    exp_q.push_back(32'h4000_0000);
    settle();
    n_cmp++; if (pcgen_vld !== 1'b1) begin n_err++; $display("FAIL hold_issue_vld: got %b want 1", pcgen_vld); end
    next_cycle();
    be_hold = 1'b1;
    settle();
    next_cycle();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL hold_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    next_cycle();
    l0btb_nxt_vld = 1'b1; l0btb_nxt_pc = 32'h8000_0020;
    exp_q.push_back(RPC);
    settle();
    next_cycle();
    l0btb_nxt_pc = 32'h8000_0030; credit_return = 1'b1;
    exp_q.push_back(32'h8000_0020);
    settle();
    next_cycle();
    drive_idle();
    exp_q.push_back(32'h8000_0030);
    settle();
    n_cmp++; if (dut.u_credit.cnt_q !== 2'd1) begin n_err++; $display("FAIL b2b_cnt: got %0d want 1", dut.u_credit.cnt_q); end
    n_cmp++; if (dut.state_q !== RUN) begin n_err++; $display("FAIL b2b_state: got %0d want %0d", dut.state_q, RUN); end
    n_cmp++; if (pcgen_vld !== 1'b1) begin n_err++; $display("FAIL b2b_vld: got %b want 1", pcgen_vld); end
    next_cycle();
    settle();
    n_cmp++; if (pcgen_vld !== 1'b0) begin n_err++; $display("FAIL b2b_stall_vld: got %b want 0", pcgen_vld); end
    next_cycle();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_midop_reset();
    apply_reset();
    next_cycle();
    exp_q.push_back(RPC);
    settle();
    next_cycle();
    be_redirect_vld = 1'b1; be_redirect_pc = 32'h7000_0000;
    settle();
    next_cycle();
    rst_n = 1'b0;
    drive_idle();
    settle();
    n_cmp++; if (pcgen_pc !== RPC) begin n_err++; $display("FAIL midrst_pc: got %h want %h", pcgen_pc, RPC); end
    n_cmp++; if (pcgen_vld !== 1'b0) begin n_err++; $display("FAIL midrst_vld: got %b want 0", pcgen_vld); end
    n_cmp++; if (dut.u_credit.cnt_q !== 2'd2) begin n_err++; $display("FAIL midrst_cnt: got %0d want 2", dut.u_credit.cnt_q); end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    exp_q.push_back(RPC);
    settle();
    next_cycle();
    exp_q.push_back(RPC);
    settle();
    next_cycle();
    settle();
    n_cmp++; if (pcgen_vld !== 1'b0) begin n_err++; $display("FAIL midrst_stall: got %b want 0", pcgen_vld); end
    next_cycle();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL midrst_pending: got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    test_reset();
    test_l0btb_chain();
    test_redirect_priority();
    test_credit_exhaust();
    test_hold();
    test_back_to_back();
    test_midop_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
